snake_step_sequencer: RTL and testbench
=======================================

// Module: snake_step_sequencer
// PURPOSE
//  Per-game-tick controller for the snake datapath. It owns the head register, the body
//  segment array and the length counter. It also sequences the collision detector:
//  compute the candidate head, request a check, wait for ready, then commit or end the game.
//  It sits between the tick/keypad logic and the collision detector; body arrays feed the detector and renderer.
// PARAMETERS
//  MAX_LEN    140  maximum snake length (head + body segments)
//  X_MIN      0    left border column (head on it = bad collision)
//  X_MAX      15   right border column
//  Y_MIN      0    top border row
//  Y_MAX      11   bottom border row
//  START_X    4    head column after reset/restart
//  START_Y    5    head row after reset/restart
//  START_LEN  3    length after reset/restart (2..MAX_LEN)
// PORTS
//  clk        in   1                   system clock
//  nrst       in   1                   asynchronous active-low reset
//  tick       in   1                   1-cycle game-step pulse
//  dir_in     in   2                   requested DIRECTION (UP=0,DOWN=1,LEFT=2,RIGHT=3)
//  restart    in   1                   synchronous re-init; honoured only in OVER
//  det_ready  in   1                   detector result valid
//  det_good   in   1                   apple hit (valid with det_ready)
//  det_bad    in   1                   wall/body hit (valid with det_ready)
//  det_start  out  1                   1-cycle check request
//  head_x/y   out  4 each              current (candidate during CHECK) head
//  tail_x/y   out  4 each              last valid body segment, body[length-2]
//  body_x/y   out  [MAX_LEN-1:0][3:0]  segment coords; index 0 nearest head; invalid slots = 0
//  length     out  $clog2(MAX_LEN+1)   current length incl. head
//  apple_req  out  1                   1-cycle pulse: respawn apple
//  step_done  out  1                   1-cycle pulse: step committed
//  game_over  out  1                   sticky until restart/reset
//  win        out  1                   sticky: length reached MAX_LEN
//  overrun    out  1                   sticky: tick arrived while busy
// BEHAVIOUR
//  Reset:
//   - head=(START_X,START_Y); length=START_LEN; dir=RIGHT.
//   - body[i]=(START_X-1-i,START_Y) for i<START_LEN-1, else 0.
//   - All pulses and flags 0. restart produces the identical state.
//  FSM IDLE->MOVE->CHECK->COMMIT->IDLE; CHECK->OVER; OVER->IDLE only on restart.
//  IDLE: a tick at cycle T moves to MOVE at T+1. A tick in any other state is dropped and sets overrun.
//  MOVE (1 cycle):
//   - dir<=dir_in unless dir_in is the opposite of dir (reversal ignored).
//   - prev<=head; head<=head stepped by the new dir. UP is y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
//   - 4-bit arithmetic.
//  CHECK:
//   - det_start=1 in the first CHECK cycle only. The detector sees the new head and the unshifted body.
//   - Wait indefinitely for det_ready. good and bad both high counts as bad.
//   - On bad: go to OVER; game_over<=1; body and length unchanged.
//   - Otherwise go to COMMIT.
//  COMMIT (1 cycle):
//   - body[0]<=prev; body[i]<=body[i-1]; step_done=1.
//   - On good: length+1, apple_req=1. If the new length==MAX_LEN, set win and game_over and go to OVER.
//   - Otherwise the slot at index length-1 is cleared to 0 (tail drop).
//  Latency: tick at T gives det_start at T+2. det_ready at R gives step_done at R+1.
//  OVER: outputs frozen; only restart leaves.
//  Reset mid-step aborts immediately to the reset state; no partial commit.
// CONFIGURATION
//  SNAKE_WRAP_EN defined:
//   - In MOVE, a step reaching X_MIN/X_MAX/Y_MIN/Y_MAX is wrapped to the opposite interior edge (X_MAX-1, X_MIN+1, ...).
//   - The head never touches the border, so det_bad arises only from body hits.
//  Undefined: the head steps onto the border and the detector reports bad.
// STRUCTURE
//  snake_pkg holds:
//   - DIRECTION enum;
//   - state enum {IDLE,MOVE,CHECK,COMMIT,OVER};
//   - COORD_W=4;
//   - opposite() function.
//  Sub-module snake_body_shiftreg: body arrays with shift, clear-slot, seed and restart ports; the FSM drives its enables.
// TESTING
//  1 Reset release -> head (4,5), length 3, body[0]=(3,5), body[1]=(2,5), body[2]=(0,0); all flags 0.
//  2 tick, dir_in=UP, det_ready 2 cycles after det_start, good=bad=0
//    -> head (4,4); body[0]=(4,5), body[1]=(3,5), body[2]=(0,0);
//       step_done 1 cycle after ready; length 3.
//  3 dir_in=LEFT while moving RIGHT, tick -> dir stays RIGHT, head x+1.
//  4 det_good=1 -> length 4, apple_req pulse, old tail kept as body[2].
//  5 det_bad=1 -> game_over; later ticks ignored and overrun set; restart -> reset state.
//  6 Head at (1,5), dir LEFT:
//    - without macro -> head (0,5), awaits det_bad;
//    - with SNAKE_WRAP_EN -> head (14,5).

Source files
------------

// File: rtl/snake_step_sequencer_pkg.sv
// rtl/snake_step_sequencer_pkg.sv - shared types and helpers for the snake step sequencer
// Purpose: direction and FSM state enums, coordinate width, reversal helper.
// Ports: none (package snake_pkg).
package snake_pkg;

  localparam int COORD_W = 4;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } direction_e;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    CHECK,
    COMMIT,
    OVER
  } state_e;

  // UP/DOWN and LEFT/RIGHT differ only in bit 0.
  function automatic direction_e opposite(input direction_e d);
    return direction_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_step_sequencer_if.sv
// rtl/snake_step_sequencer_if.sv - tick/detector/status bundle of the snake step sequencer
// Purpose: groups the game-step, detector handshake and snake state outputs.
// Ports: master = tick/keypad + detector side, slave = sequencer.
//   tick, dir_in, restart, det_ready, det_good, det_bad : master -> slave
//   det_start, head_*, tail_*, body_*, length, apple_req,
//   step_done, game_over, win, overrun                  : slave -> master
interface snake_step_sequencer_if #(
  parameter int MAX_LEN = 140
);
  import snake_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                              tick;
  logic [1:0]                        dir_in;
  logic                              restart;
  logic                              det_ready;
  logic                              det_good;
  logic                              det_bad;
  logic                              det_start;
  logic [COORD_W-1:0]                head_x;
  logic [COORD_W-1:0]                head_y;
  logic [COORD_W-1:0]                tail_x;
  logic [COORD_W-1:0]                tail_y;
  logic [MAX_LEN-1:0][COORD_W-1:0]   body_x;
  logic [MAX_LEN-1:0][COORD_W-1:0]   body_y;
  logic [LEN_W-1:0]                  length;
  logic                              apple_req;
  logic                              step_done;
  logic                              game_over;
  logic                              win;
  logic                              overrun;

  modport master (
    output tick, dir_in, restart, det_ready, det_good, det_bad,
    input  det_start, head_x, head_y, tail_x, tail_y, body_x, body_y,
           length, apple_req, step_done, game_over, win, overrun
  );

  modport slave (
    input  tick, dir_in, restart, det_ready, det_good, det_bad,
    output det_start, head_x, head_y, tail_x, tail_y, body_x, body_y,
           length, apple_req, step_done, game_over, win, overrun
  );

endinterface

// File: rtl/snake_step_sequencer_body_shiftreg.sv
// rtl/snake_step_sequencer_body_shiftreg.sv - snake body segment array with shift and tail drop
// Purpose: holds body segments (index 0 nearest the head); shifts in the old head,
//   optionally clears one slot in the same cycle, re-seeds the start pattern on restart.
// Ports: clk, nrst (async active-low); i_shift, i_clear_en, i_clear_idx,
//   i_seed_x/y (old head), i_restart; o_body_x/y segment arrays.
module snake_body_shiftreg
  import snake_pkg::*;
#(
  parameter  int MAX_LEN   = 140,
  parameter  int START_X   = 4,
  parameter  int START_Y   = 5,
  parameter  int START_LEN = 3,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            i_shift,
  input  logic                            i_clear_en,
  input  logic [LEN_W-1:0]                i_clear_idx,
  input  logic [COORD_W-1:0]              i_seed_x,
  input  logic [COORD_W-1:0]              i_seed_y,
  input  logic                            i_restart,
  output logic [MAX_LEN-1:0][COORD_W-1:0] o_body_x,
  output logic [MAX_LEN-1:0][COORD_W-1:0] o_body_y
);

  typedef logic [MAX_LEN-1:0][COORD_W-1:0] body_t;

  // Start pattern: a horizontal tail trailing left of the start head.
  function automatic body_t init_x();
    body_t v;
    for (int i = 0; i < MAX_LEN; i++) begin
      v[i] = (i < START_LEN - 1) ? COORD_W'(START_X - 1 - i) : '0;
    end
    return v;
  endfunction

  function automatic body_t init_y();
    body_t v;
    for (int i = 0; i < MAX_LEN; i++) begin
      v[i] = (i < START_LEN - 1) ? COORD_W'(START_Y) : '0;
    end
    return v;
  endfunction

  body_t r_body_x;
  body_t r_body_y;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_body_x <= init_x();
      r_body_y <= init_y();
    end else if (i_restart) begin
      r_body_x <= init_x();
      r_body_y <= init_y();
    end else if (i_shift) begin
      r_body_x[0] <= i_seed_x;
      r_body_y[0] <= i_seed_y;
      // Clearing the slot the old tail shifted into keeps invalid slots at 0.
      for (int i = 1; i < MAX_LEN; i++) begin
        if (i_clear_en && (LEN_W'(i) == i_clear_idx)) begin
          r_body_x[i] <= '0;
          r_body_y[i] <= '0;
        end else begin
          r_body_x[i] <= r_body_x[i-1];
          r_body_y[i] <= r_body_y[i-1];
        end
      end
    end
  end

  assign o_body_x = r_body_x;
  assign o_body_y = r_body_y;

endmodule

// File: rtl/snake_step_sequencer.sv
// rtl/snake_step_sequencer.sv - per-tick snake head/body/length controller and detector sequencer
// Purpose: on each tick steps the head, asks the collision detector, then commits
//   the move (shift body, grow on apple) or ends the game.
// Ports: clk, nrst (async active-low), bus (snake_step_sequencer_if.slave).
// Build option: SNAKE_WRAP_EN wraps the head to the opposite interior edge
//   instead of letting it step onto the border.
module snake_step_sequencer
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 140,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 15,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 11,
  parameter int START_X   = 4,
  parameter int START_Y   = 5,
  parameter int START_LEN = 3
) (
  input logic                    clk,
  input logic                    nrst,
  snake_step_sequencer_if.slave  bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_e             r_state;
  direction_e         r_dir;
  logic [COORD_W-1:0] r_head_x, r_head_y;
  logic [COORD_W-1:0] r_prev_x, r_prev_y;
  logic [LEN_W-1:0]   r_length;
  logic               r_det_start, r_apple_req, r_step_done;
  logic               r_game_over, r_win, r_overrun;

  direction_e         w_dir_new;
  logic [COORD_W-1:0] w_step_x, w_step_y, w_next_x, w_next_y;
  logic               w_shift, w_clear_en, w_restart;
  logic [LEN_W-1:0]   w_clear_idx, w_tail_idx;
  logic [MAX_LEN-1:0][COORD_W-1:0] w_body_x, w_body_y;

  // Candidate head: reversal is ignored, then one 4-bit step, then optional wrap.
  always_comb begin
    w_dir_new = (direction_e'(bus.dir_in) == opposite(r_dir)) ? r_dir : direction_e'(bus.dir_in);
    w_step_x  = r_head_x;
    w_step_y  = r_head_y;
    unique case (w_dir_new)
      UP:    w_step_y = r_head_y - ONE;
      DOWN:  w_step_y = r_head_y + ONE;
      LEFT:  w_step_x = r_head_x - ONE;
      RIGHT: w_step_x = r_head_x + ONE;
    endcase
    w_next_x = w_step_x;
    w_next_y = w_step_y;
    if (WRAP_EN) begin
      if (w_step_x == COORD_W'(X_MIN))      w_next_x = COORD_W'(X_MAX - 1);
      else if (w_step_x == COORD_W'(X_MAX)) w_next_x = COORD_W'(X_MIN + 1);
      if (w_step_y == COORD_W'(Y_MIN))      w_next_y = COORD_W'(Y_MAX - 1);
      else if (w_step_y == COORD_W'(Y_MAX)) w_next_y = COORD_W'(Y_MIN + 1);
    end
  end

  // Body shifts on the cycle the detector answers without a bad hit, so the
  // committed body is visible while step_done is high. det_bad wins over det_good.
  assign w_shift     = (r_state == CHECK) && bus.det_ready && !bus.det_bad;
  assign w_clear_en  = !bus.det_good;
  assign w_clear_idx = r_length - LEN_W'(1);
  assign w_restart   = (r_state == OVER) && bus.restart;
  assign w_tail_idx  = r_length - LEN_W'(2);

  snake_body_shiftreg #(
    .MAX_LEN   (MAX_LEN),
    .START_X   (START_X),
    .START_Y   (START_Y),
    .START_LEN (START_LEN)
  ) u_body (
    .clk         (clk),
    .nrst        (nrst),
    .i_shift     (w_shift),
    .i_clear_en  (w_clear_en),
    .i_clear_idx (w_clear_idx),
    .i_seed_x    (r_prev_x),
    .i_seed_y    (r_prev_y),
    .i_restart   (w_restart),
    .o_body_x    (w_body_x),
    .o_body_y    (w_body_y)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_dir       <= RIGHT;
      r_head_x    <= COORD_W'(START_X);
      r_head_y    <= COORD_W'(START_Y);
      r_prev_x    <= COORD_W'(START_X);
      r_prev_y    <= COORD_W'(START_Y);
      r_length    <= LEN_W'(START_LEN);
      r_det_start <= 1'b0;
      r_apple_req <= 1'b0;
      r_step_done <= 1'b0;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_det_start <= 1'b0;
      r_apple_req <= 1'b0;
      r_step_done <= 1'b0;
      if (bus.tick && (r_state != IDLE)) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.tick) r_state <= MOVE;
        end
        MOVE: begin
          r_dir       <= w_dir_new;
          r_prev_x    <= r_head_x;
          r_prev_y    <= r_head_y;
          r_head_x    <= w_next_x;
          r_head_y    <= w_next_y;
          r_det_start <= 1'b1;
          r_state     <= CHECK;
        end
        CHECK: begin
          if (bus.det_ready) begin
            if (bus.det_bad) begin
              r_game_over <= 1'b1;
              r_state     <= OVER;
            end else begin
              r_step_done <= 1'b1;
              r_state     <= COMMIT;
              if (bus.det_good) begin
                r_length    <= r_length + LEN_W'(1);
                r_apple_req <= 1'b1;
                if ((r_length + LEN_W'(1)) == LEN_W'(MAX_LEN)) begin
                  r_win       <= 1'b1;
                  r_game_over <= 1'b1;
                end
              end
            end
          end
        end
        COMMIT: begin
          r_state <= r_win ? OVER : IDLE;
        end
        OVER: begin
          if (bus.restart) begin
            r_state     <= IDLE;
            r_dir       <= RIGHT;
            r_head_x    <= COORD_W'(START_X);
            r_head_y    <= COORD_W'(START_Y);
            r_prev_x    <= COORD_W'(START_X);
            r_prev_y    <= COORD_W'(START_Y);
            r_length    <= LEN_W'(START_LEN);
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
            r_overrun   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.det_start = r_det_start;
  assign bus.head_x    = r_head_x;
  assign bus.head_y    = r_head_y;
  assign bus.tail_x    = w_body_x[w_tail_idx];
  assign bus.tail_y    = w_body_y[w_tail_idx];
  assign bus.body_x    = w_body_x;
  assign bus.body_y    = w_body_y;
  assign bus.length    = r_length;
  assign bus.apple_req = r_apple_req;
  assign bus.step_done = r_step_done;
  assign bus.game_over = r_game_over;
  assign bus.win       = r_win;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_snake_step_sequencer.sv
// tb/tb_snake_step_sequencer.sv - table-driven self-checking bench for snake_step_sequencer
module tb_snake_step_sequencer;
  import snake_pkg::*;

  localparam int MAX_LEN = 140;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  snake_step_sequencer_if #(.MAX_LEN(MAX_LEN)) bus();

  snake_step_sequencer #(
    .MAX_LEN(MAX_LEN), .X_MIN(0), .X_MAX(15), .Y_MIN(0), .Y_MAX(11),
    .START_X(4), .START_Y(5), .START_LEN(3)
  ) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] d;
    logic       g;
    logic       b;
    int         dly;
    int         hx, hy, len;
    int         b0x, b0y, b1x, b1y, b2x, b2y;
    int         tx, ty;
    int         over;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " head_x"}, bus.head_x, 4);
    chk({tag, " head_y"}, bus.head_y, 5);
    chk({tag, " length"}, bus.length, 3);
    chk({tag, " body0_x"}, bus.body_x[0], 3);
    chk({tag, " body0_y"}, bus.body_y[0], 5);
    chk({tag, " body1_x"}, bus.body_x[1], 2);
    chk({tag, " body1_y"}, bus.body_y[1], 5);
    chk({tag, " body2_x"}, bus.body_x[2], 0);
    chk({tag, " body2_y"}, bus.body_y[2], 0);
    chk({tag, " body_last"}, bus.body_x[MAX_LEN-1], 0);
    chk({tag, " tail_x"}, bus.tail_x, 2);
    chk({tag, " tail_y"}, bus.tail_y, 5);
    chk({tag, " det_start"}, bus.det_start, 0);
    chk({tag, " apple_req"}, bus.apple_req, 0);
    chk({tag, " step_done"}, bus.step_done, 0);
    chk({tag, " game_over"}, bus.game_over, 0);
    chk({tag, " win"}, bus.win, 0);
    chk({tag, " overrun"}, bus.overrun, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  // One full game step; detector answers dly cycles after det_start.
  task automatic step(input logic [1:0] d, input logic g, input logic b,
                      input int dly, input bit full);
    @(negedge clk);
    bus.tick   = 1'b1;
    bus.dir_in = d;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    if (full) chk("det_start_latency", bus.det_start, 1);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      if (full && k == 0) chk("det_start_width", bus.det_start, 0);
    end
    bus.det_ready = 1'b1;
    bus.det_good  = g;
    bus.det_bad   = b;
    @(negedge clk);
    bus.det_ready = 1'b0;
    bus.det_good  = 1'b0;
    bus.det_bad   = 1'b0;
    if (full) begin
      chk("step_done_pulse", bus.step_done, int'(!b));
      chk("apple_req_pulse", bus.apple_req, int'(g && !b));
    end
    @(negedge clk);
    if (full) chk("step_done_width", bus.step_done, 0);
  endtask

  initial begin
    nrst          = 1'b0;
    bus.tick      = 1'b0;
    bus.dir_in    = 2'd3;
    bus.restart   = 1'b0;
    bus.det_ready = 1'b0;
    bus.det_good  = 1'b0;
    bus.det_bad   = 1'b0;

    //          d     g     b     dly hx hy len b0x b0y b1x b1y b2x b2y tx ty over
    vt[0] = '{2'd0, 1'b0, 1'b0, 2,  4, 4, 3,  4,  5,  3,  5,  0,  0,  3, 5, 0};
    vt[1] = '{2'd3, 1'b0, 1'b0, 1,  5, 4, 3,  4,  4,  4,  5,  0,  0,  4, 5, 0};
    vt[2] = '{2'd2, 1'b0, 1'b0, 3,  6, 4, 3,  5,  4,  4,  4,  0,  0,  4, 4, 0};
    vt[3] = '{2'd1, 1'b1, 1'b0, 1,  6, 5, 4,  6,  4,  5,  4,  4,  4,  4, 4, 0};
    vt[4] = '{2'd1, 1'b0, 1'b0, 0,  6, 6, 4,  6,  5,  6,  4,  5,  4,  5, 4, 0};
    vt[5] = '{2'd2, 1'b1, 1'b1, 1,  5, 6, 4,  6,  5,  6,  4,  5,  4,  5, 4, 1};

    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check_reset("reset");

    for (int i = 0; i < 6; i++) begin
      step(vt[i].d, vt[i].g, vt[i].b, vt[i].dly, 1'b1);
      chk($sformatf("v%0d head_x", i), bus.head_x, vt[i].hx);
      chk($sformatf("v%0d head_y", i), bus.head_y, vt[i].hy);
      chk($sformatf("v%0d length", i), bus.length, vt[i].len);
      chk($sformatf("v%0d body0_x", i), bus.body_x[0], vt[i].b0x);
      chk($sformatf("v%0d body0_y", i), bus.body_y[0], vt[i].b0y);
      chk($sformatf("v%0d body1_x", i), bus.body_x[1], vt[i].b1x);
      chk($sformatf("v%0d body1_y", i), bus.body_y[1], vt[i].b1y);
      chk($sformatf("v%0d body2_x", i), bus.body_x[2], vt[i].b2x);
      chk($sformatf("v%0d body2_y", i), bus.body_y[2], vt[i].b2y);
      chk($sformatf("v%0d body3_x", i), bus.body_x[3], 0);
      chk($sformatf("v%0d tail_x", i), bus.tail_x, vt[i].tx);
      chk($sformatf("v%0d tail_y", i), bus.tail_y, vt[i].ty);
      chk($sformatf("v%0d game_over", i), bus.game_over, vt[i].over);
      chk($sformatf("v%0d overrun", i), bus.overrun, 0);
    end

    // In OVER: tick is dropped, overrun set, state frozen; restart re-inits.
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    chk("over det_start", bus.det_start, 0);
    chk("over overrun", bus.overrun, 1);
    chk("over game_over", bus.game_over, 1);
    chk("over head_x", bus.head_x, 5);
    chk("over length", bus.length, 4);
    pulse_restart();
    check_reset("restart");

    // Tick while busy sets sticky overrun; LEFT after restart is a reversal.
    @(negedge clk);
    bus.tick   = 1'b1;
    bus.dir_in = 2'd2;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    chk("busy det_start", bus.det_start, 1);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    chk("busy overrun", bus.overrun, 1);
    bus.det_ready = 1'b1;
    @(negedge clk);
    bus.det_ready = 1'b0;
    chk("busy step_done", bus.step_done, 1);
    @(negedge clk);
    chk("busy head_x", bus.head_x, 5);
    chk("busy head_y", bus.head_y, 5);
    chk("busy overrun sticky", bus.overrun, 1);

    // Reset in the middle of CHECK aborts to the reset state.
    @(negedge clk);
    bus.tick   = 1'b1;
    bus.dir_in = 2'd0;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge clk);
    nrst = 1'b1;

    // Walk the head to (1,5) heading LEFT, then step onto the left border.
    step(2'd0, 1'b0, 1'b0, 1, 1'b0);
    step(2'd2, 1'b0, 1'b0, 1, 1'b0);
    step(2'd2, 1'b0, 1'b0, 1, 1'b0);
    step(2'd1, 1'b0, 1'b0, 1, 1'b0);
    step(2'd2, 1'b0, 1'b0, 1, 1'b0);
    chk("edge pre head_x", bus.head_x, 1);
    chk("edge pre head_y", bus.head_y, 5);
    pulse_restart();
    chk("idle restart ignored", bus.head_x, 1);
    @(negedge clk);
    bus.tick   = 1'b1;
    bus.dir_in = 2'd2;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
`ifdef SNAKE_WRAP_EN
    chk("edge cand head_x", bus.head_x, 14);
    chk("edge cand head_y", bus.head_y, 5);
    bus.det_ready = 1'b1;
    @(negedge clk);
    bus.det_ready = 1'b0;
    chk("edge wrap step_done", bus.step_done, 1);
    @(negedge clk);
    chk("edge wrap head_x", bus.head_x, 14);
    chk("edge wrap game_over", bus.game_over, 0);
`else
    chk("edge cand head_x", bus.head_x, 0);
    chk("edge cand head_y", bus.head_y, 5);
    bus.det_ready = 1'b1;
    bus.det_bad   = 1'b1;
    @(negedge clk);
    bus.det_ready = 1'b0;
    bus.det_bad   = 1'b0;
    chk("edge bad step_done", bus.step_done, 0);
    chk("edge bad game_over", bus.game_over, 1);
    chk("edge bad length", bus.length, 3);
`endif
    do_reset();

    // Grow to MAX_LEN: win and game_over together; nothing is ever dropped.
    for (int n = 0; n < MAX_LEN - 4; n++) step(2'd3, 1'b1, 1'b0, 0, 1'b0);
    chk("prewin length", bus.length, MAX_LEN - 1);
    chk("prewin win", bus.win, 0);
    chk("prewin game_over", bus.game_over, 0);
    step(2'd3, 1'b1, 1'b0, 1, 1'b1);
    chk("win length", bus.length, MAX_LEN);
    chk("win flag", bus.win, 1);
    chk("win game_over", bus.game_over, 1);
    chk("win tail_x", bus.tail_x, 2);
    chk("win tail_y", bus.tail_y, 5);
    chk("win last slot", bus.body_x[MAX_LEN-1], 0);
    pulse_restart();
    check_reset("after_win");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
